regfile_write_scheduler: RTL
============================

// Module: regfile_write_scheduler
// PURPOSE
//  Owns the single write port of the 4x16-bit register file. Arbitrates it between
//  the pipeline writeback stage and a long-latency unit (memory/multiply return).
//  Holds deferred LU writes in a small FIFO and keeps a per-register pending
//  scoreboard. Decode uses the scoreboard to stall on RAW/WAW hazards.
//  Sits between WB/LU and the RegisterFiles write inputs (ctrlRegWrite/writeReg/writeData).
// PARAMETERS
//  WORD_SIZE   16  data width; the default is `WORD_SIZE
//  NUM_REGS    4   architectural registers; the default is `NUM_REGS
//  REG_AW      2   register address width, log2(NUM_REGS)
//  BUF_DEPTH   2   LU deferral FIFO entries; must be a power of 2, >=2
// PORTS
//  clk            in   1         single clock; all state updates on posedge
//  reset_n        in   1         asynchronous, active-low reset
//  wb_valid       in   1         writeback request; always accepted, never back-pressured
//  wb_reg         in   REG_AW    writeback destination
//  wb_data        in   WORD_SIZE writeback value
//  lu_valid       in   1         LU write request (valid/ready)
//  lu_ready       out  1         LU request accepted this cycle when lu_valid&lu_ready
//  lu_reg         in   REG_AW    LU destination
//  lu_data        in   WORD_SIZE LU value
//  issue_valid    in   1         long-latency op issuing, marks issue_dst pending
//  issue_dst      in   REG_AW    destination of the issuing op
//  rd1, rd2       in   REG_AW    source registers of the instruction in decode
//  stall          out  1         decode must hold (combinational)
//  pending        out  NUM_REGS  scoreboard bits, registered
//  rf_write       out  1         to ctrlRegWrite, registered
//  rf_write_reg   out  REG_AW    to writeReg, registered
//  rf_write_data  out  WORD_SIZE to writeData, registered
// BEHAVIOUR
//  Reset (async assert): rf_write=0, rf_write_reg=0, rf_write_data=0, pending=0,
//   FIFO emptied, lu_ready=0. After deassertion lu_ready=1 from the first clk edge.
//   Reset asserted mid-operation discards buffered LU writes. No partial write is emitted.
//  Port selection per cycle, evaluated at posedge t; the outputs are valid in cycle t+1:
//   1) wb_valid: write wb_reg/wb_data.
//   2) else FIFO non-empty: pop the head and write it.
//   3) else lu_valid&lu_ready with FIFO empty: bypass. The LU write appears at t+1.
//   4) else rf_write=0. The reg and data outputs hold their previous values.
//  An accepted LU request that is not written this cycle is pushed to the FIFO tail.
//   Order is strictly FIFO across LU writes.
//  lu_ready = FIFO not full. It is registered and reflects occupancy after edge t.
//   On a simultaneous push and pop when full, lu_ready stays 0 for that cycle.
//  WB latency 1 cycle. LU latency 1 cycle when unblocked, otherwise 1 + cycles behind WB/FIFO.
//   WB starvation of LU is permitted. The pipeline never issues WB back-to-back indefinitely.
//  Scoreboard:
//   - pending[issue_dst] is set at the edge where issue_valid & !stall.
//   - pending[r] is cleared at the edge where an LU write to r is placed on rf_write.
//   - Set and clear of the same register in the same edge: set wins.
//  stall = pending[rd1] | pending[rd2] | (issue_valid & pending[issue_dst]).
//   This covers RAW and WAW hazards. Issue while stall is asserted is ignored.
//  A WB write to a register with pending=1 is written but does not clear the bit (WAW ordering).
//  FIFO pointers are REG-wide modulo BUF_DEPTH with a separate count. Wrap-around is silent.
//   A push on full cannot occur, because lu_ready gates it.
// STRUCTURE
//  Shared include opcodes.v: `WORD_SIZE and `NUM_REGS exist; add `REG_AW (2) there.
//  One sub-module: rf_write_fifo (BUF_DEPTH x {REG_AW, WORD_SIZE}, push/pop/full/empty,
//   async active-low reset). Arbitration and scoreboard stay in the top level.
// TESTING
//  1 Reset: hold reset_n=0 -> rf_write=0, pending=0, lu_ready=0; release -> lu_ready=1 next edge.
//  2 WB only: wb_valid,reg=2,data=16'h1234 -> next cycle rf_write=1,reg=2,data=1234; r2 reads 1234.
//  3 Conflict: wb(1,16'hAAAA)+lu(3,16'h5555) same cycle -> t+1 writes r1=AAAA, t+2 writes r3=5555.
//  4 Backpressure: 4 cycles of wb_valid with lu_valid held -> 2 LU accepted, lu_ready=0, then
//    WB stops -> FIFO drains in order, lu_ready returns to 1, no LU value lost or reordered.
//  5 Scoreboard: issue r2; rd1=2 -> stall=1; LU writes r2 -> pending[2]=0, stall=0 the next cycle.
//    Issue r2 in the same edge as its LU clear -> pending[2] stays 1.
//  6 Mid-op reset: FIFO holding 2 entries, pulse reset_n low -> no rf_write, FIFO empty, pending=0.

Source files
------------

// File: rtl/regfile_write_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_write_scheduler_pkg                                |
// | Brief   : Shared sizing constants and write-port select encoding.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_write_scheduler_pkg;

  localparam int c_WORD_SIZE = 16;
  localparam int c_NUM_REGS  = 4;
  localparam int c_REG_AW    = 2;
  localparam int c_BUF_DEPTH = 2;

  // Which source owns the register-file write port in a given cycle
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_WB     = 2'd1,
    SEL_FIFO   = 2'd2,
    SEL_BYPASS = 2'd3
  } wsel_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_scheduler_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_write_fifo                                              |
// | Brief   : Small FIFO of deferred long-latency register writes.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_write_fifo
  import regfile_write_scheduler_pkg::*;
#(
  parameter int REG_AW    = c_REG_AW,
  parameter int WORD_SIZE = c_WORD_SIZE,
  parameter int BUF_DEPTH = c_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [REG_AW-1:0]    pushReg,
  input  logic [WORD_SIZE-1:0] pushData,
  input  logic                 pop,
  output logic [REG_AW-1:0]    headReg,
  output logic [WORD_SIZE-1:0] headData,
  output logic                 full,
  output logic                 almostFull,
  output logic                 empty
);

  localparam int c_PTR_W = $clog2(BUF_DEPTH);
  localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);

  logic [REG_AW+WORD_SIZE-1:0] r_mem [BUF_DEPTH];
  logic [c_PTR_W-1:0]          r_wrPtr;
  logic [c_PTR_W-1:0]          r_rdPtr;
  logic [c_CNT_W-1:0]          r_count;

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + c_PTR_W'(1);
      if (pop)  r_rdPtr <= r_rdPtr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(push) - c_CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wrPtr] <= {pushReg, pushData};
  end

  assign {headReg, headData} = r_mem[r_rdPtr];
  assign full                = (r_count == c_CNT_W'(BUF_DEPTH));
  assign almostFull          = (r_count == c_CNT_W'(BUF_DEPTH - 1));
  assign empty               = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile_write_scheduler                                    |
// | Brief   : Register-file write-port arbiter (WB vs LU) + scoreboard.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int WORD_SIZE = c_WORD_SIZE,
  parameter int NUM_REGS  = c_NUM_REGS,
  parameter int REG_AW    = c_REG_AW,
  parameter int BUF_DEPTH = c_BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_valid,
  input  logic [REG_AW-1:0]    wb_reg,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [REG_AW-1:0]    lu_reg,
  input  logic [WORD_SIZE-1:0] lu_data,
  input  logic                 issue_valid,
  input  logic [REG_AW-1:0]    issue_dst,
  input  logic [REG_AW-1:0]    rd1,
  input  logic [REG_AW-1:0]    rd2,
  output logic                 stall,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 rf_write,
  output logic [REG_AW-1:0]    rf_write_reg,
  output logic [WORD_SIZE-1:0] rf_write_data
);

  logic                 r_rfWrite;
  logic [REG_AW-1:0]    r_rfWriteReg;
  logic [WORD_SIZE-1:0] r_rfWriteData;
  logic [NUM_REGS-1:0]  r_pending;
  logic                 r_luReady;

  wsel_t                w_sel;
  logic [REG_AW-1:0]    w_wrReg;
  logic [WORD_SIZE-1:0] w_wrData;
  logic                 w_luAccept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_nextFull;
  logic [REG_AW-1:0]    w_headReg;
  logic [WORD_SIZE-1:0] w_headData;
  logic                 w_fifoFull;
  logic                 w_fifoAlmostFull;
  logic                 w_fifoEmpty;
  logic [NUM_REGS-1:0]  w_setMask;
  logic [NUM_REGS-1:0]  w_clearMask;
  logic [NUM_REGS-1:0]  w_pendingNext;

  assign w_luAccept = lu_valid & r_luReady;

  // Fixed priority: WB, then buffered LU (oldest first), then LU bypass
  always_comb begin
    w_sel    = SEL_NONE;
    w_wrReg  = wb_reg;
    w_wrData = wb_data;
    if (wb_valid) begin
      w_sel = SEL_WB;
    end else if (!w_fifoEmpty) begin
      w_sel    = SEL_FIFO;
      w_wrReg  = w_headReg;
      w_wrData = w_headData;
    end else if (w_luAccept) begin
      w_sel    = SEL_BYPASS;
      w_wrReg  = lu_reg;
      w_wrData = lu_data;
    end
  end

  assign w_pop  = (w_sel == SEL_FIFO);
  assign w_push = w_luAccept & (w_sel != SEL_BYPASS);

  // Occupancy after this edge; push without pop can only move almost-full to full
  assign w_nextFull = (w_push & !w_pop) ? (w_fifoAlmostFull | w_fifoFull) :
                      (w_pop & !w_push) ? 1'b0 : w_fifoFull;

  rf_write_fifo #(
    .REG_AW    (REG_AW),
    .WORD_SIZE (WORD_SIZE),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (w_push),
    .pushReg    (lu_reg),
    .pushData   (lu_data),
    .pop        (w_pop),
    .headReg    (w_headReg),
    .headData   (w_headData),
    .full       (w_fifoFull),
    .almostFull (w_fifoAlmostFull),
    .empty      (w_fifoEmpty)
  );

  assign stall = r_pending[rd1] | r_pending[rd2] | (issue_valid & r_pending[issue_dst]);

  // Only LU writes retire a pending bit; a new issue to the same register wins
  assign w_clearMask   = (w_pop || w_sel == SEL_BYPASS) ? (NUM_REGS'(1) << w_wrReg) : '0;
  assign w_setMask     = (issue_valid && !stall) ? (NUM_REGS'(1) << issue_dst) : '0;
  assign w_pendingNext = (r_pending & ~w_clearMask) | w_setMask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rfWrite     <= 1'b0;
      r_rfWriteReg  <= '0;
      r_rfWriteData <= '0;
      r_pending     <= '0;
      r_luReady     <= 1'b0;
    end else begin
      r_rfWrite <= (w_sel != SEL_NONE);
      if (w_sel != SEL_NONE) begin
        r_rfWriteReg  <= w_wrReg;
        r_rfWriteData <= w_wrData;
      end
      r_pending <= w_pendingNext;
      r_luReady <= !w_nextFull;
    end
  end

  assign lu_ready      = r_luReady;
  assign pending       = r_pending;
  assign rf_write      = r_rfWrite;
  assign rf_write_reg  = r_rfWriteReg;
  assign rf_write_data = r_rfWriteData;

endmodule
`default_nettype wire
